// File: rtl/rs_erasure_flag_writer_pkg.sv
// Shared RS decoder definitions: codeword geometry and the erasure-flag writer FSM encoding.
package rs_erasure_flag_writer_pkg;

  localparam int unsigned RS_N  = 255;
  localparam int unsigned RS_T2 = 16;
  localparam int unsigned RS_AW = 8;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/rs_erasure_flag_writer.sv
// Writes one erasure flag per symbol into the flag RAM, counts erasures per codeword,
// and holds the stream off until the downstream locator acknowledges the codeword.
module rs_erasure_flag_writer
  import rs_erasure_flag_writer_pkg::*;
#(
  parameter int unsigned N  = RS_N,
  parameter int unsigned T2 = RS_T2,
  parameter int unsigned AW = RS_AW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic          in_erasure,
  output logic          in_ready,
  output logic          flag_wren,
  output logic [AW-1:0] flag_wraddress,
  output logic          flag_data,
  output logic          cw_valid,
  output logic [AW-1:0] cw_erasure_count,
  output logic          cw_uncorrectable,
  output logic          cw_length_error,
  input  logic          cw_ack
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [AW-1:0] count_n, count_inc;
  logic          err_n;
  logic          wr_n;
  logic          accept;

  assign accept    = in_valid & in_ready;
  assign count_inc = (cw_erasure_count == '1) ? cw_erasure_count
                                              : cw_erasure_count + AW'(in_erasure);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    count_n = cw_erasure_count;
    err_n   = cw_length_error;
    wr_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && in_sop) begin
          wr_n    = 1'b1;
          idx_n   = '0;
          count_n = AW'(in_erasure);
          err_n   = in_eop;
          state_n = in_eop ? FLUSH : CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_n = 1'b1;
          if (in_sop) begin
            // Restart: the new codeword inherits a sticky length error.
            idx_n   = '0;
            count_n = AW'(in_erasure);
            err_n   = 1'b1;
            if (in_eop) state_n = FLUSH;
          end else begin
            idx_n   = idx + AW'(1);
            count_n = count_inc;
            if (in_eop) begin
              state_n = FLUSH;
              err_n   = cw_length_error | (idx_n != LAST);
            end else if (idx_n == LAST) begin
              state_n = FLUSH;
              err_n   = 1'b1;
            end
          end
        end
      end
      FLUSH: state_n = DONE;
      DONE:  if (cw_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      idx              <= '0;
      in_ready         <= 1'b0;
      flag_wren        <= 1'b0;
      flag_wraddress   <= '0;
      flag_data        <= 1'b0;
      cw_valid         <= 1'b0;
      cw_erasure_count <= '0;
      cw_uncorrectable <= 1'b0;
      cw_length_error  <= 1'b0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      in_ready         <= (state_n == IDLE) || (state_n == CAPTURE);
      flag_wren        <= wr_n;
      cw_valid         <= (state_n == DONE);
      cw_erasure_count <= count_n;
      cw_uncorrectable <= (32'(count_n) > T2);
      cw_length_error  <= err_n;
      if (wr_n) begin
        flag_wraddress <= idx_n;
        flag_data      <= in_erasure;
      end
    end
  end

endmodule
